// File: rtl/ksa_swap_engine.sv
// RC4 key-scheduling engine: optional identity fill of S followed by the
// KSA swap pass, all through a single-port request/complete memory handshake.
// Every output is a register loaded from the next-state values, so the memory
// request, address, data and direction are stable while an op is pending.
module ksa_swap_engine #(
    parameter int ADDR_W       = 8,
    parameter int KEY_LEN      = 3,
    parameter bit INIT_DEFAULT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [KEY_LEN*ADDR_W-1:0] secretKey,
    input  logic                      init_mode,
    input  logic                      init_mode_valid,
    input  logic                      start_Task2a,
    output logic                      finish_Task2a,
    output logic [ADDR_W-1:0]         address,
    output logic [ADDR_W-1:0]         data_out,
    output logic                      readWrite,
    output logic                      start_readWrite_op,
    input  logic [ADDR_W-1:0]         data_in,
    input  logic                      finish_readWrite_op,
    output logic                      busy
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [KW-1:0]     LAST_KEY = KW'(KEY_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RD_SI = 3'd2,
        RD_SJ = 3'd3,
        WR_SI = 3'd4,
        WR_SJ = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t                      state, nxt_state;
    logic [ADDR_W-1:0]           i, j, si, sj;
    logic [ADDR_W-1:0]           nxt_i, nxt_j, nxt_si, nxt_sj;
    logic [KW-1:0]               kidx, nxt_kidx;
    logic [KEY_LEN*ADDR_W-1:0]   key_r, nxt_key, key_sh;
    logic [ADDR_W-1:0]           key_elem;
    logic                        op_done, fill_sel;
    logic [ADDR_W-1:0]           nxt_address, nxt_data_out;
    logic                        nxt_readWrite, nxt_start_op, nxt_finish, nxt_busy;

    assign op_done  = start_readWrite_op & finish_readWrite_op;
    assign fill_sel = init_mode_valid ? init_mode : INIT_DEFAULT;

    // Select the current key element: element 0 sits in the top ADDR_W bits.
    always_comb begin
        key_sh   = key_r << (int'(kidx) * ADDR_W);
        key_elem = key_sh[KEY_LEN*ADDR_W-1 -: ADDR_W];
    end

    // Next-state, index and held-value computation for the KSA sequence.
    always_comb begin
        nxt_state = state;
        nxt_i     = i;
        nxt_j     = j;
        nxt_si    = si;
        nxt_sj    = sj;
        nxt_kidx  = kidx;
        nxt_key   = key_r;
        case (state)
            IDLE: begin
                if (start_Task2a) begin
                    nxt_key   = secretKey;
                    nxt_i     = '0;
                    nxt_j     = '0;
                    nxt_kidx  = '0;
                    nxt_state = fill_sel ? FILL : RD_SI;
                end else begin
                    nxt_state = IDLE;
                end
            end
            FILL: begin
                if (op_done) begin
                    if (i == LAST_IDX) begin
                        nxt_i     = '0;
                        nxt_state = RD_SI;
                    end else begin
                        nxt_i = i + ADDR_W'(1);
                    end
                end else begin
                    nxt_state = FILL;
                end
            end
            RD_SI: begin
                if (op_done) begin
                    nxt_si    = data_in;
                    nxt_j     = j + data_in + key_elem;
                    nxt_state = RD_SJ;
                end else begin
                    nxt_state = RD_SI;
                end
            end
            RD_SJ: begin
                if (op_done) begin
                    nxt_sj    = data_in;
                    nxt_state = WR_SI;
                end else begin
                    nxt_state = RD_SJ;
                end
            end
            WR_SI: begin
                if (op_done) begin
                    nxt_state = WR_SJ;
                end else begin
                    nxt_state = WR_SI;
                end
            end
            WR_SJ: begin
                if (op_done) begin
                    if (i == LAST_IDX) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_i     = i + ADDR_W'(1);
                        nxt_kidx  = (kidx == LAST_KEY) ? '0 : kidx + KW'(1);
                        nxt_state = RD_SI;
                    end
                end else begin
                    nxt_state = WR_SJ;
                end
            end
            DONE: begin
                if (start_Task2a) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs can be registered.
    always_comb begin
        nxt_address   = '0;
        nxt_data_out  = '0;
        nxt_readWrite = 1'b0;
        nxt_start_op  = 1'b0;
        nxt_finish    = 1'b0;
        nxt_busy      = 1'b1;
        case (nxt_state)
            FILL: begin
                nxt_start_op  = 1'b1;
                nxt_readWrite = 1'b1;
                nxt_address   = nxt_i;
                nxt_data_out  = nxt_i;
            end
            RD_SI: begin
                nxt_start_op = 1'b1;
                nxt_address  = nxt_i;
            end
            RD_SJ: begin
                nxt_start_op = 1'b1;
                nxt_address  = nxt_j;
            end
            WR_SI: begin
                nxt_start_op  = 1'b1;
                nxt_readWrite = 1'b1;
                nxt_address   = nxt_i;
                nxt_data_out  = nxt_sj;
            end
            WR_SJ: begin
                nxt_start_op  = 1'b1;
                nxt_readWrite = 1'b1;
                nxt_address   = nxt_j;
                nxt_data_out  = nxt_si;
            end
            DONE: begin
                nxt_finish = 1'b1;
                nxt_busy   = 1'b0;
            end
            default: begin
                nxt_busy = 1'b0;
            end
        endcase
    end

    // State, working registers and registered outputs; reset abandons any op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            i                  <= '0;
            j                  <= '0;
            si                 <= '0;
            sj                 <= '0;
            kidx               <= '0;
            key_r              <= '0;
            address            <= '0;
            data_out           <= '0;
            readWrite          <= 1'b0;
            start_readWrite_op <= 1'b0;
            finish_Task2a      <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= nxt_state;
            i                  <= nxt_i;
            j                  <= nxt_j;
            si                 <= nxt_si;
            sj                 <= nxt_sj;
            kidx               <= nxt_kidx;
            key_r              <= nxt_key;
            address            <= nxt_address;
            data_out           <= nxt_data_out;
            readWrite          <= nxt_readWrite;
            start_readWrite_op <= nxt_start_op;
            finish_Task2a      <= nxt_finish;
            busy               <= nxt_busy;
        end
    end

endmodule
